// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU arbiter: MDU operation encodings and FSM states.
package mdu_pkg;

    // MDU operation encoding (RISC-V M-extension funct3 order)
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int MDU_XLEN = 32;

    // Arbiter sequencing: accept -> start pulse -> wait for MDU -> return result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping around. Produces a one-hot grant, its index, and an any-grant flag.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Scan requesters starting from the pointer; the first hit wins.
    always_comb begin
        int w_cand;
        // NOTE: every output gets a default before the scan so no path can infer a latch.
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_valid && i_req[w_cand]) begin
                o_valid       = 1'b1;
                o_idx         = IDX_W'(w_cand);
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one multicycle MDU between NUM_REQ requesters. Grants round-robin,
// latches the winning operation, issues it with a one-cycle start pulse, waits
// for the MDU completion pulse and hands the result back over a valid/ready channel.
module mdu_arbiter
    import mdu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [3*NUM_REQ-1:0]    req_op_i,
    input  logic [32*NUM_REQ-1:0]   req_rs1_i,
    input  logic [32*NUM_REQ-1:0]   req_rs2_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    mdu_valid_o,
    output logic [2:0]              mdu_op_o,
    output logic [31:0]             mdu_rs1_o,
    output logic [31:0]             mdu_rs2_o,
    input  logic                    mdu_ready_i,
    input  logic [31:0]             mdu_rd_i,
    output logic                    busy_o
);

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [2:0]           r_op;
    logic [31:0]          r_rs1;
    logic [31:0]          r_rs2;
    logic [31:0]          r_result;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_any;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_any)
    );

    // A grant is only ever made from IDLE.
    assign w_accept   = (r_state == IDLE) && w_gnt_any;
    assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // State register; reset aborts any in-flight operation without a response.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        w_next      = r_state;
        req_ready_o = '0;
        rsp_valid_o = '0;
        mdu_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (w_gnt_any) begin
                    req_ready_o = w_gnt;
                    w_next      = ISSUE;
                end
            end
            ISSUE: begin
                mdu_valid_o = 1'b1;
                w_next      = WAIT;
            end
            WAIT: begin
                if (mdu_ready_i) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[r_gnt_idx] = 1'b1;
                if (rsp_ready_i[r_gnt_idx]) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the granted operation and pointer on accept; capture the MDU result in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_op      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_gnt_idx <= w_gnt_idx;
                r_rr_ptr  <= w_ptr_next;
                r_op      <= req_op_i[3*w_gnt_idx +: 3];
                r_rs1     <= req_rs1_i[MDU_XLEN*w_gnt_idx +: MDU_XLEN];
                r_rs2     <= req_rs2_i[MDU_XLEN*w_gnt_idx +: MDU_XLEN];
            end
            if ((r_state == WAIT) && mdu_ready_i) begin
                r_result <= mdu_rd_i;
            end
        end
    end

    // The MDU only ever sees the latched copy, so requesters may change inputs after accept.
    assign mdu_op_o   = r_op;
    assign mdu_rs1_o  = r_rs1;
    assign mdu_rs2_o  = r_rs2;
    assign rsp_data_o = r_result;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a behavioural multicycle MDU attached.
module tb_mdu_arbiter;
    import mdu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int MDU_LAT = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [3*NUM_REQ-1:0]  req_op_i;
    logic [32*NUM_REQ-1:0] req_rs1_i;
    logic [32*NUM_REQ-1:0] req_rs2_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [31:0]           rsp_data_o;
    logic                  mdu_valid_o;
    logic [2:0]            mdu_op_o;
    logic [31:0]           mdu_rs1_o;
    logic [31:0]           mdu_rs2_o;
    logic                  mdu_ready_i;
    logic [31:0]           mdu_rd_i;
    logic                  busy_o;

    logic                  m_ready;
    logic                  spur;
    assign mdu_ready_i = m_ready | spur;

    int n_pass       = 0;
    int n_total      = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    mdu_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_rs1_i   (req_rs1_i),
        .req_rs2_i   (req_rs2_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .mdu_valid_o (mdu_valid_o),
        .mdu_op_o    (mdu_op_o),
        .mdu_rs1_o   (mdu_rs1_o),
        .mdu_rs2_o   (mdu_rs2_o),
        .mdu_ready_i (mdu_ready_i),
        .mdu_rd_i    (mdu_rd_i),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    endtask

    // Behavioural MDU arithmetic (RISC-V M-extension semantics).
    function automatic logic [31:0] mdu_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        case (op)
            MDU_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            MDU_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            MDU_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            MDU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default:    return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // MDU model: start on the valid pulse, answer MDU_LAT cycles later with a
    // one-cycle ready pulse, checking that the operands stayed stable meanwhile.
    logic [2:0]  m_op;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    int          m_cnt = 0;

    initial begin
        m_ready  = 1'b0;
        mdu_rd_i = 32'd0;
    end

    always @(negedge clk) begin
        m_ready = 1'b0;
        if (mdu_valid_o) valid_cycles++;
        if (rst) begin
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                check("op_stable",  32'(mdu_op_o), 32'(m_op));
                check("rs1_stable", mdu_rs1_o, m_rs1);
                check("rs2_stable", mdu_rs2_o, m_rs2);
                mdu_rd_i = mdu_calc(m_op, m_rs1, m_rs2);
                m_ready  = 1'b1;
            end
        end else if (mdu_valid_o) begin
            m_op  = mdu_op_o;
            m_rs1 = mdu_rs1_o;
            m_rs2 = mdu_rs2_o;
            m_cnt = MDU_LAT;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op_i[3*idx +: 3]   = op;
        req_rs1_i[32*idx +: 32] = a;
        req_rs2_i[32*idx +: 32] = b;
    endtask

    task automatic wait_any_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready_o != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_accept_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid_o != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_rsp_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One full transaction from a single requester, scrambling its inputs after accept.
    task automatic run_op(input string tag, input int idx, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int vc0;
        set_req(idx, op, a, b);
        req_valid_i[idx] = 1'b1;
        #1;
        vc0 = valid_cycles;
        wait_any_ready(tag);
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'(1 << idx));
        tick();
        req_valid_i[idx] = 1'b0;
        set_req(idx, op ^ 3'b111, ~a, a ^ b);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        wait_rsp(tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'(1 << idx));
        check({tag, "_rsp_data"}, rsp_data_o, exp);
        check({tag, "_issue_pulses"}, 32'(valid_cycles - vc0), 32'd1);
        rsp_ready_i[idx] = 1'b1;
        tick();
        rsp_ready_i[idx] = 1'b0;
        check({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
        check({tag, "_rsp_drop"}, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        rst         = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_op_i    = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        spur        = 1'b0;
        do_reset();

        // Reset state
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data",  rsp_data_o, 32'd0);
        check("rst_mdu_valid", 32'(mdu_valid_o), 32'd0);
        check("rst_mdu_op",    32'(mdu_op_o), 32'd0);
        check("rst_mdu_rs1",   mdu_rs1_o, 32'd0);
        check("rst_mdu_rs2",   mdu_rs2_o, 32'd0);
        check("rst_busy",      32'(busy_o), 32'd0);

        // 1. Single MUL from requester 0
        run_op("mul", 0, MDU_MUL, 32'd7, 32'd6, 32'd42);

        // 2. Both requesters continuously valid: grants alternate 0,1,0,1...
        do_reset();
        set_req(0, MDU_MUL, 32'd3, 32'd5);
        set_req(1, MDU_MUL, 32'd4, 32'd5);
        req_valid_i = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_d = ((k % 2) == 1) ? 32'd20 : 32'd15;
            wait_any_ready("rr");
            check("rr_grant", 32'(req_ready_o), 32'(1 << (k % 2)));
            tick();
            check("rr_no_grant_busy", 32'(req_ready_o), 32'd0);
            wait_rsp("rr");
            check("rr_rsp_valid", 32'(rsp_valid_o), 32'(1 << (k % 2)));
            check("rr_rsp_data", rsp_data_o, exp_d);
            rsp_ready_i = rsp_valid_o;
            if (k == 7) req_valid_i = '0;
            tick();
            rsp_ready_i = '0;
        end
        tick();
        check("rr_idle_after", 32'(busy_o), 32'd0);

        // 3. Signed divide and remainder-by-zero from requester 1
        run_op("div",  1, MDU_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_op("remu", 1, MDU_REMU, 32'd20,        32'd0, 32'd20);

        // 4. Response backpressure for 50 cycles while requester 1 waits
        set_req(0, MDU_MUL, 32'd7, 32'd6);
        req_valid_i[0] = 1'b1;
        #1;
        wait_any_ready("bp");
        check("bp_grant0", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i[0] = 1'b0;
        set_req(0, MDU_DIVU, 32'd0, 32'd0);
        set_req(1, MDU_MUL, 32'd2, 32'd3);
        req_valid_i[1] = 1'b1;
        #1;
        wait_rsp("bp");
        for (int c = 0; c < 50; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_rsp_data",  rsp_data_o, 32'd42);
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
            check("bp_busy",      32'(busy_o), 32'd1);
            tick();
        end
        rsp_ready_i[0] = 1'b1;
        tick();
        rsp_ready_i[0] = 1'b0;
        check("bp_grant1", 32'(req_ready_o), 32'd2);
        tick();
        req_valid_i[1] = 1'b0;
        wait_rsp("bp1");
        check("bp1_rsp_valid", 32'(rsp_valid_o), 32'd2);
        check("bp1_rsp_data",  rsp_data_o, 32'd6);
        rsp_ready_i[1] = 1'b1;
        tick();
        rsp_ready_i[1] = 1'b0;

        // 5. Reset while a DIV is waiting on the MDU
        set_req(0, MDU_DIV, 32'd100, 32'd7);
        req_valid_i[0] = 1'b1;
        #1;
        wait_any_ready("rstw");
        tick();
        req_valid_i[0] = 1'b0;
        tick();
        check("rstw_in_wait", 32'(busy_o), 32'd1);
        check("rstw_no_pulse", 32'(mdu_valid_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy",      32'(busy_o), 32'd0);
        check("rstw_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rstw_rsp_data",  rsp_data_o, 32'd0);
        check("rstw_mdu_valid", 32'(mdu_valid_o), 32'd0);
        check("rstw_mdu_op",    32'(mdu_op_o), 32'd0);
        check("rstw_mdu_rs1",   mdu_rs1_o, 32'd0);
        check("rstw_mdu_rs2",   mdu_rs2_o, 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rstw_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        run_op("mulhu", 0, MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1);

        // 6. Spurious MDU completion in IDLE is ignored
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_busy",      32'(busy_o), 32'd0);
        check("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("spur_mdu_valid", 32'(mdu_valid_o), 32'd0);
        tick();
        check("spur_busy2", 32'(busy_o), 32'd0);
        run_op("mulh", 1, MDU_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
